// File: rtl/uart_lite_slave.sv
// UART-Lite register map behind an AXI4-Lite slave port.
// Bridges bus accesses to byte-stream TX/RX ports, with one FIFO in each direction.

module uart_lite_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        do_pop    = pop && (count != '0) && !clr;
        do_push   = push && (!full || do_pop) && !clr;
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
endmodule

module uart_lite_slave #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_err,
    output logic              interrupt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] REG_RX   = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic             active;
    logic             aw_held;
    logic             w_held;
    logic [1:0]       aw_sel;
    logic [7:0]       wdata_reg;
    logic             wstrb0_reg;
    logic             aw_hs;
    logic             w_hs;
    logic             commit;
    logic             tx_push_req;
    logic             ctrl_wr;
    logic             tx_clr;
    logic             rx_clr;

    logic             ar_hs;
    logic [1:0]       ar_sel;
    logic             rx_pop_req;
    logic             stat_rd;
    logic [7:0]       rdata_reg;
    logic [7:0]       rdata_nxt;
    logic [7:0]       stat;

    logic [7:0]       tx_head;
    logic [7:0]       rx_head;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] tx_cnt_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] rx_cnt_nxt;
    logic             tx_pop;
    logic             rx_full;
    logic             tx_full;
    logic             intr_en;
    logic             overrun;
    logic             frame_err;
    logic             overrun_set;

    logic             unused_bits;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    // Readies stay low through reset and the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) active <= 1'b0;
        else     active <= 1'b1;
    end

    // Handshake rule on every channel: a transfer happens on a rising edge where valid and ready
    // are both 1; the source holds its payload stable from raising valid until that edge.
    always_comb begin
        w_state_nxt   = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        commit        = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = active && !aw_held;
                s_axi_wready  = active && !w_held;
                commit        = aw_held && w_held;
                if (commit) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign s_axi_bresp = 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_sel     <= 2'd0;
            wdata_reg  <= 8'd0;
            wstrb0_reg <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_sel  <= s_axi_awaddr[3:2];
            end
            if (w_hs) begin
                w_held     <= 1'b1;
                wdata_reg  <= s_axi_wdata[7:0];
                wstrb0_reg <= s_axi_wstrb[0];
            end
            if (w_state == W_RESP && s_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    assign tx_push_req = commit && wstrb0_reg && (aw_sel == REG_TX);
    assign ctrl_wr     = commit && wstrb0_reg && (aw_sel == REG_CTRL);
    assign tx_clr      = ctrl_wr && wdata_reg[0];
    assign rx_clr      = ctrl_wr && wdata_reg[1];

    always_comb begin
        r_state_nxt   = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = active;
                if (s_axi_arvalid && active) r_state_nxt = R_RESP;
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign ar_sel      = s_axi_araddr[3:2];
    assign rx_pop_req  = ar_hs && (ar_sel == REG_RX) && (rx_cnt != '0);
    assign stat_rd     = ar_hs && (ar_sel == REG_STAT);
    assign s_axi_rresp = 2'b00;
    assign s_axi_rdata = {24'd0, rdata_reg};

    assign rx_full = (rx_cnt == CNT_W'(FIFO_DEPTH));
    assign tx_full = (tx_cnt == CNT_W'(FIFO_DEPTH));
    assign stat    = {1'b0, frame_err, overrun, intr_en, tx_full, (tx_cnt == '0), rx_full, (rx_cnt != '0)};

    always_comb begin
        rdata_nxt = 8'd0;
        case (ar_sel)
            REG_RX:   rdata_nxt = (rx_cnt != '0) ? rx_head : 8'd0;
            REG_STAT: rdata_nxt = stat;
            default:  rdata_nxt = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            rdata_reg <= 8'd0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) rdata_reg <= rdata_nxt;
        end
    end

    assign tx_valid = (tx_cnt != '0);
    assign tx_data  = tx_head;
    assign tx_pop   = tx_valid && tx_ready;

    uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (tx_clr),
        .push      (tx_push_req),
        .wdata     (wdata_reg),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_cnt),
        .count_nxt (tx_cnt_nxt)
    );

    uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (rx_clr),
        .push      (rx_valid),
        .wdata     (rx_data),
        .pop       (rx_pop_req),
        .head      (rx_head),
        .count     (rx_cnt),
        .count_nxt (rx_cnt_nxt)
    );

    // A byte lost to a full RX FIFO is an overrun only when no read frees a slot that cycle.
    assign overrun_set = rx_valid && rx_full && !rx_pop_req;

    // New error events win over a STAT read that clears in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_en   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (ctrl_wr) intr_en <= wdata_reg[4];
            overrun   <= overrun_set || (overrun && !stat_rd);
            frame_err <= (rx_valid && rx_frame_err) || (frame_err && !stat_rd);
            interrupt <= intr_en && (((rx_cnt == '0) && (rx_cnt_nxt != '0)) ||
                                     ((tx_cnt != '0) && (tx_cnt_nxt == '0)));
        end
    end
endmodule
